// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared types and defaults for the counter scheduler
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    int          c;
    logic [PW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        win_o   = '0;
        idx_o   = '0;
        c       = 0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            c    = (int'(ptr_i) + k) % NREQ;
            cand = PW'(c);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                win_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin owner of a shared up-counter: clear, run len counts, pulse done
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] len,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic            cnt_enable,
    output logic            cnt_clear,
    input  logic [W-1:0]    cnt_value
);

    localparam int PW = $clog2(NREQ);

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   gidx_q;
    logic [W-1:0]    len_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;
    logic            clear_q;

    logic [NREQ-1:0] win;
    logic [PW-1:0]   widx;
    logic            wvalid;
    logic [PW-1:0]   ptr_nxt;
    logic            req_own;
    logic            at_len;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .idx_o   (widx),
        .valid_o (wvalid)
    );

    assign ptr_nxt = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
    assign req_own = req[gidx_q];
    assign at_len  = (cnt_value == len_q);

    // Enable is combinational so a dropped request stops the counter in the same cycle.
    assign cnt_enable = (state_q == RUN) && !at_len && req_own;
    assign busy       = (state_q != IDLE);
    assign grant      = grant_q;
    assign done       = done_q;
    assign cnt_clear  = clear_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            len_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            clear_q <= 1'b0;
        end else begin
            done_q  <= '0;
            clear_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wvalid) begin
                        gidx_q  <= widx;
                        grant_q <= win;
                        len_q   <= len[widx*W +: W];
                        clear_q <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: state_q <= RUN;
                RUN: begin
                    if (at_len) begin
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else if (!req_own) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_nxt;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    ptr_q   <= ptr_nxt;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
